// File: rtl/alu_issue_ctrl_if.sv
// Bus between the issue controller (master) and the combinational 16-bit ALU (slave).
// Operands/op flow master->slave; result and flags flow back.
interface alu_issue_ctrl_if #(
    parameter int unsigned DATA_W = 16
);
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [3:0]        alu_op;
    logic [DATA_W-1:0] alu_rd;
    logic              alu_bne;
    logic              alu_ov;

    modport master (
        output alu_a, alu_b, alu_op,
        input  alu_rd, alu_bne, alu_ov
    );

    modport slave (
        input  alu_a, alu_b, alu_op,
        output alu_rd, alu_bne, alu_ov
    );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Multicycle issue/writeback controller driving a combinational ALU from an 8x16 register file.
// Optional macro ALU_OV_TRAP_EN: ADD/SUB overflow suppresses writeback and pulses ov_trap.
module alu_issue_ctrl #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned NREGS  = 8,
    parameter int unsigned ADDR_W = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                instr_valid,
    input  logic [15:0]         instr,
    output logic                instr_ready,
    input  logic                ld_en,
    input  logic [ADDR_W-1:0]   ld_addr,
    input  logic [DATA_W-1:0]   ld_data,
    alu_issue_ctrl_if.master    alu,
    output logic                done,
    output logic                branch_taken,
    output logic                illegal,
`ifdef ALU_OV_TRAP_EN
    output logic                ov_trap,
`endif
    input  logic [ADDR_W-1:0]   dbg_addr,
    output logic [DATA_W-1:0]   dbg_data
);

    typedef enum logic [1:0] {StIdle, StRead, StExec, StWb} state_e;

    state_e state_q, state_d;

    logic [15:0]       ir_q;
    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] alu_a_q, alu_b_q;
    logic [3:0]        alu_op_q;
    logic [DATA_W-1:0] result_q;
    logic              bne_q, ov_q;

    logic [ADDR_W-1:0] rs_idx, rt_idx, rd_idx;
    logic [3:0]        op_map;
    logic              op_legal, op_bne, op_arith;
    logic              accept, trap, wb_en;

    assign rs_idx = ADDR_W'(ir_q[11:9]);
    assign rt_idx = ADDR_W'(ir_q[8:6]);
    assign rd_idx = ADDR_W'(ir_q[5:3]);

    // Opcode -> ALU op; op_arith marks the ops whose overflow flag is meaningful.
    always_comb begin
        op_map   = 4'd0;
        op_legal = 1'b1;
        op_bne   = 1'b0;
        op_arith = 1'b0;
        case (ir_q[15:12])
            4'h0: op_map = 4'd0;
            4'h1: op_map = 4'd1;
            4'h2: begin op_map = 4'd2; op_arith = 1'b1; end
            4'h6: begin op_map = 4'd6; op_arith = 1'b1; end
            4'h7: op_map = 4'd7;
            4'hB: begin op_map = 4'd6; op_bne = 1'b1; end
            default: op_legal = 1'b0;
        endcase
    end

    function automatic logic [DATA_W-1:0] read_reg(input logic [ADDR_W-1:0] idx,
                                                  input logic [DATA_W-1:0] val);
        return (idx == '0) ? '0 : val;
    endfunction

`ifdef ALU_OV_TRAP_EN
    assign trap = op_arith && ov_q;
    logic unused_bits;
    assign unused_bits = ^ir_q[2:0];
`else
    assign trap = 1'b0;
    logic unused_bits;
    assign unused_bits = ^{ir_q[2:0], ov_q, op_arith};
`endif

    assign accept = (state_q == StIdle) && instr_valid && instr_ready;
    assign wb_en  = (state_q == StWb) && op_legal && !op_bne && !trap && (rd_idx != '0);

    always_ff @(posedge clk) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d      = state_q;
        instr_ready  = 1'b0;
        done         = 1'b0;
        branch_taken = 1'b0;
        illegal      = 1'b0;
`ifdef ALU_OV_TRAP_EN
        ov_trap      = 1'b0;
`endif
        unique case (state_q)
            StIdle: begin
                instr_ready = !rst;
                if (accept) state_d = StRead;
            end
            StRead: state_d = op_legal ? StExec : StWb;
            StExec: state_d = StWb;
            StWb: begin
                // Gated by rst so a reset landing in WB never retires the instruction.
                done         = !rst;
                branch_taken = !rst && op_legal && op_bne && bne_q;
                illegal      = !rst && !op_legal;
`ifdef ALU_OV_TRAP_EN
                ov_trap      = !rst && op_legal && trap;
`endif
                state_d      = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(NREGS); i++) regs_q[i] <= '0;
            ir_q     <= '0;
            alu_a_q  <= '0;
            alu_b_q  <= '0;
            alu_op_q <= '0;
            result_q <= '0;
            bne_q    <= 1'b0;
            ov_q     <= 1'b0;
        end else begin
            // Preload and writeback live in disjoint states, so they never collide.
            if (state_q == StIdle && ld_en && ld_addr != '0) regs_q[ld_addr] <= ld_data;
            if (wb_en) regs_q[rd_idx] <= result_q;
            if (accept) ir_q <= instr;
            if (state_q == StRead) begin
                alu_a_q  <= read_reg(rs_idx, regs_q[rs_idx]);
                alu_b_q  <= read_reg(rt_idx, regs_q[rt_idx]);
                alu_op_q <= op_map;
            end
            if (state_q == StExec) begin
                result_q <= alu.alu_rd;
                bne_q    <= alu.alu_bne;
                ov_q     <= alu.alu_ov;
            end
        end
    end

    assign alu.alu_a  = alu_a_q;
    assign alu.alu_b  = alu_b_q;
    assign alu.alu_op = alu_op_q;

    assign dbg_data = read_reg(dbg_addr, regs_q[dbg_addr]);

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl with a behavioural 16-bit ALU as responder.
module tb_alu_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic [15:0] instr;
    logic        instr_ready;
    logic        ld_en;
    logic [2:0]  ld_addr;
    logic [15:0] ld_data;
    logic        done, branch_taken, illegal;
    logic [2:0]  dbg_addr;
    logic [15:0] dbg_data;
`ifdef ALU_OV_TRAP_EN
    logic        ov_trap;
`endif

    alu_issue_ctrl_if #(.DATA_W(16)) alu_bus ();

    alu_issue_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .instr_valid  (instr_valid),
        .instr        (instr),
        .instr_ready  (instr_ready),
        .ld_en        (ld_en),
        .ld_addr      (ld_addr),
        .ld_data      (ld_data),
        .alu          (alu_bus.master),
        .done         (done),
        .branch_taken (branch_taken),
        .illegal      (illegal),
`ifdef ALU_OV_TRAP_EN
        .ov_trap      (ov_trap),
`endif
        .dbg_addr     (dbg_addr),
        .dbg_data     (dbg_data)
    );

    always #10 clk = ~clk;

    // Responder ALU
    always_comb begin
        alu_bus.alu_rd = 16'h0000;
        alu_bus.alu_ov = 1'b0;
        case (alu_bus.alu_op)
            4'd0: alu_bus.alu_rd = alu_bus.alu_a & alu_bus.alu_b;
            4'd1: alu_bus.alu_rd = alu_bus.alu_a | alu_bus.alu_b;
            4'd2: begin
                alu_bus.alu_rd = alu_bus.alu_a + alu_bus.alu_b;
                alu_bus.alu_ov = (alu_bus.alu_a[15] == alu_bus.alu_b[15]) &&
                                 (alu_bus.alu_rd[15] != alu_bus.alu_a[15]);
            end
            4'd6: begin
                alu_bus.alu_rd = alu_bus.alu_a - alu_bus.alu_b;
                alu_bus.alu_ov = (alu_bus.alu_a[15] != alu_bus.alu_b[15]) &&
                                 (alu_bus.alu_rd[15] != alu_bus.alu_a[15]);
            end
            4'd7: alu_bus.alu_rd = ($signed(alu_bus.alu_a) < $signed(alu_bus.alu_b)) ?
                                   16'h0001 : 16'h0000;
            default: alu_bus.alu_rd = 16'h0000;
        endcase
        alu_bus.alu_bne = (alu_bus.alu_rd != 16'h0000);
    end

    typedef struct {
        int          lat;
        bit          ill;
        bit          br;
        bit          trap;
        bit          wen;
        logic [2:0]  wrd;
        logic [15:0] wdata;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] mdl [8];
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
        end
    endtask

    task automatic check_regs(input string tag);
        for (int i = 0; i < 8; i++) begin
            dbg_addr = 3'(i);
            #1;
            check_eq($sformatf("%s r%0d", tag, i), {16'h0, dbg_data}, {16'h0, mdl[i]});
        end
    endtask

    task automatic preload(input logic [2:0] a, input logic [15:0] v);
        @(negedge clk);
        ld_en = 1'b1; ld_addr = a; ld_data = v;
        @(posedge clk); #1;
        ld_en = 1'b0;
        if (a != 3'd0) mdl[a] = v;
    endtask

    // Issue one instruction (optionally with a same-cycle preload) and retire it.
    task automatic issue(input string tag, input logic [3:0] opc, input logic [2:0] rs,
                         input logic [2:0] rt, input logic [2:0] rd,
                         input bit do_ld, input logic [2:0] la, input logic [15:0] lv);
        exp_t        e;
        logic [15:0] a, b, r;
        bit          ov, legal, seen;
        int          n;
        n = 0;
        while (!instr_ready && n < 10) begin @(posedge clk); #1; n++; end
        check_eq({tag, " ready"}, {31'h0, instr_ready}, 32'h1);
        @(negedge clk);
        instr_valid = 1'b1;
        instr = {opc, rs, rt, rd, 3'b000};
        if (do_ld) begin
            ld_en = 1'b1; ld_addr = la; ld_data = lv;
            if (la != 3'd0) mdl[la] = lv;
        end
        a = mdl[rs]; b = mdl[rt]; ov = 1'b0; legal = 1'b1; r = 16'h0;
        case (opc)
            4'h0: r = a & b;
            4'h1: r = a | b;
            4'h2: begin r = a + b; ov = (a[15] == b[15]) && (r[15] != a[15]); end
            4'h6, 4'hB: begin r = a - b; ov = (a[15] != b[15]) && (r[15] != a[15]); end
            4'h7: r = ($signed(a) < $signed(b)) ? 16'h1 : 16'h0;
            default: legal = 1'b0;
        endcase
        e.lat   = legal ? 2 : 1;
        e.ill   = !legal;
        e.br    = (opc == 4'hB) && (a != b);
`ifdef ALU_OV_TRAP_EN
        e.trap  = (opc == 4'h2 || opc == 4'h6) && ov;
`else
        e.trap  = 1'b0;
`endif
        e.wen   = legal && (opc != 4'hB) && !e.trap;
        e.wrd   = rd;
        e.wdata = r;
        sb.push_back(e);
        @(posedge clk); #1;
        instr_valid = 1'b0;
        // Preload outside IDLE must be ignored.
        ld_en = 1'b1; ld_addr = 3'd4; ld_data = 16'hDEAD;
        seen = 1'b0; n = 0;
        while (!seen && n < 8) begin @(posedge clk); #1; n++; seen = done; end
        e = sb.pop_front();
        if (!seen) begin
            check_eq({tag, " done timeout"}, 32'h0, 32'h1);
        end else begin
            check_eq({tag, " latency"}, n, e.lat);
            check_eq({tag, " illegal"}, {31'h0, illegal}, {31'h0, e.ill});
            check_eq({tag, " branch"}, {31'h0, branch_taken}, {31'h0, e.br});
`ifdef ALU_OV_TRAP_EN
            check_eq({tag, " ov_trap"}, {31'h0, ov_trap}, {31'h0, e.trap});
`endif
            if (e.wen && e.wrd != 3'd0) mdl[e.wrd] = e.wdata;
        end
        @(posedge clk); #1;
        ld_en = 1'b0;
        check_eq({tag, " done pulse"}, {31'h0, done}, 32'h0);
        check_regs(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; instr_valid = 1'b0; instr = 16'h0;
        ld_en = 1'b0; ld_addr = 3'd0; ld_data = 16'h0; dbg_addr = 3'd0;
        for (int i = 0; i < 8; i++) mdl[i] = 16'h0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("ready in rst", {31'h0, instr_ready}, 32'h0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        check_eq("ready after rst", {31'h0, instr_ready}, 32'h1);
        check_eq("done after rst", {31'h0, done}, 32'h0);
        check_eq("alu_a after rst", {16'h0, alu_bus.alu_a}, 32'h0);
        check_eq("alu_op after rst", {28'h0, alu_bus.alu_op}, 32'h0);
        check_regs("reset");

        preload(3'd1, 16'h0005);
        preload(3'd2, 16'h0003);
        preload(3'd0, 16'h1234);
        issue("add", 4'h2, 3'd1, 3'd2, 3'd3, 1'b0, 3'd0, 16'h0);
        issue("sub", 4'h6, 3'd1, 3'd2, 3'd4, 1'b0, 3'd0, 16'h0);
        issue("slt", 4'h7, 3'd2, 3'd1, 3'd5, 1'b0, 3'd0, 16'h0);
        issue("bne taken", 4'hB, 3'd1, 3'd2, 3'd3, 1'b0, 3'd0, 16'h0);
        issue("bne not", 4'hB, 3'd1, 3'd1, 3'd3, 1'b0, 3'd0, 16'h0);
        issue("add rd0", 4'h2, 3'd1, 3'd2, 3'd0, 1'b0, 3'd0, 16'h0);
        issue("illegal", 4'hF, 3'd1, 3'd2, 3'd6, 1'b0, 3'd0, 16'h0);
        issue("and", 4'h0, 3'd1, 3'd2, 3'd6, 1'b0, 3'd0, 16'h0);
        issue("or", 4'h1, 3'd1, 3'd2, 3'd7, 1'b0, 3'd0, 16'h0);
        issue("rd eq rs", 4'h2, 3'd1, 3'd2, 3'd1, 1'b0, 3'd0, 16'h0);
        issue("ld same cycle", 4'h2, 3'd1, 3'd2, 3'd7, 1'b1, 3'd1, 16'h0010);

        preload(3'd1, 16'h7FFF);
        preload(3'd2, 16'h0001);
        issue("add ov", 4'h2, 3'd1, 3'd2, 3'd6, 1'b0, 3'd0, 16'h0);

        // Reset during EXEC discards the instruction.
        @(negedge clk);
        instr_valid = 1'b1;
        instr = {4'h2, 3'd1, 3'd2, 3'd3, 3'b000};
        @(posedge clk); #1;
        instr_valid = 1'b0;
        @(posedge clk); #1;
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        check_eq("rst done", {31'h0, done}, 32'h0);
        check_eq("rst ready", {31'h0, instr_ready}, 32'h0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        check_eq("post rst ready", {31'h0, instr_ready}, 32'h1);
        check_eq("post rst done", {31'h0, done}, 32'h0);
        for (int i = 0; i < 8; i++) mdl[i] = 16'h0;
        check_regs("post rst");
        check_eq("sb empty", sb.size(), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
        $finish;
    end

endmodule
